// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the 256x4 SRAM BIST response analyzer
package bist_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 4;
  localparam int ENTRY_W = ADDR_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
    logic [DATA_W-1:0] act;
  } fail_entry_t;

  // One read-latency pipeline stage: the tag of a read still waiting for its data.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } rd_tag_t;

endpackage

// File: rtl/bist_fail_fifo.sv
// rtl/bist_fail_fifo.sv - synchronous fail-log FIFO of fail_entry_t records
module bist_fail_fifo
  import bist_pkg::*;
#(
  parameter int LOG_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int PTR_W = $clog2(LOG_DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  fail_entry_t      mem_q [LOG_DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W + 1)'(LOG_DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clr_i && do_push) mem_q[wr_ptr_q] <= fail_entry_t'(push_data_i);
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - compares SRAM read data against expected, counts and logs failures
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int LOG_DEPTH = 4,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              end_of_test,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              we_in,
  input  logic [DATA_W-1:0] exp_in,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [DATA_W-1:0] fail_bits,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_exp,
  output logic [DATA_W-1:0] log_act,
  input  logic              log_pop,
  output logic              log_ovf
);

  localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        drain_q, drain_d;
  rd_tag_t           pipe_q [RD_LAT];
  rd_tag_t           cap, tail;
  logic [DATA_W-1:0] diff;
  logic              mismatch;
  logic [CNT_W-1:0]  err_q;
  logic [DATA_W-1:0] fail_bits_q;
  logic              ovf_q;
  logic              fifo_full, fifo_empty;
  fail_entry_t       push_entry, head_entry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (start) begin
      state_d = RUN;
      drain_d = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (end_of_test) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) state_d = DONE;
          else                       drain_d = drain_q + 3'd1;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == DRAIN);
    done = (state_q == DONE);
    pass = (state_q == DONE) && (err_q == '0);
  end

  always_comb begin
    cap = '0;
    if (state_q == RUN && !we_in) begin
      cap.vld  = 1'b1;
      cap.addr = addr_in;
      cap.exp  = exp_in;
    end
  end

  // Each read tag travels RD_LAT stages so it meets its own data at the tail.
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= cap;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail     = pipe_q[RD_LAT-1];
  assign diff     = tail.exp ^ sram_dout;
  assign mismatch = tail.vld && (diff != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      err_q       <= '0;
      fail_bits_q <= '0;
      ovf_q       <= 1'b0;
    end else if (mismatch) begin
      if (err_q != {CNT_W{1'b1}}) err_q <= err_q + CNT_W'(1);
      fail_bits_q <= fail_bits_q | diff;
      if (fifo_full && !log_pop) ovf_q <= 1'b1;
    end
  end

  assign push_entry = '{addr: tail.addr, exp: tail.exp, act: sram_dout};

  bist_fail_fifo #(
    .LOG_DEPTH(LOG_DEPTH)
  ) u_fail_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start),
    .push_i     (mismatch),
    .push_data_i(push_entry),
    .pop_i      (log_pop),
    .head_o     (head_entry),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign err_count = err_q;
  assign fail_bits = fail_bits_q;
  assign log_ovf   = ovf_q;
  assign log_valid = !fifo_empty;
  assign log_addr  = head_entry.addr;
  assign log_exp   = head_entry.exp;
  assign log_act   = head_entry.act;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - self-checking bench: dut_a RD_LAT=1/CNT_W=10, dut_b RD_LAT=2/CNT_W=2
module tb_bist_response_analyzer;
  import bist_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, eot, we, log_pop;
  logic [7:0]  addr;
  logic [3:0]  exp_d, fault;
  logic [3:0]  act_now, dout_a, dly_b, dout_b;

  logic        a_busy, a_done, a_pass, a_valid, a_ovf;
  logic [9:0]  a_err;
  logic [3:0]  a_fb, a_lexp, a_lact;
  logic [7:0]  a_laddr;
  logic        b_busy, b_done, b_pass, b_valid, b_ovf;
  logic [1:0]  b_err;
  logic [3:0]  b_fb, b_lexp, b_lact;
  logic [7:0]  b_laddr;

  int checks = 0;
  int failures = 0;
  fail_entry_t sb_q[$];

  typedef struct {
    logic [7:0] addr;
    logic [3:0] exp;
    logic [3:0] mask;
    int         err;
    logic [3:0] fb;
  } row_t;
  row_t rows[6];

  bist_response_analyzer #(.RD_LAT(1), .LOG_DEPTH(4), .CNT_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .end_of_test(eot), .addr_in(addr),
    .we_in(we), .exp_in(exp_d), .sram_dout(dout_a), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err), .fail_bits(a_fb), .log_valid(a_valid),
    .log_addr(a_laddr), .log_exp(a_lexp), .log_act(a_lact), .log_pop(log_pop), .log_ovf(a_ovf)
  );

  bist_response_analyzer #(.RD_LAT(2), .LOG_DEPTH(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .end_of_test(eot), .addr_in(addr),
    .we_in(we), .exp_in(exp_d), .sram_dout(dout_b), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err), .fail_bits(b_fb), .log_valid(b_valid),
    .log_addr(b_laddr), .log_exp(b_lexp), .log_act(b_lact), .log_pop(log_pop), .log_ovf(b_ovf)
  );

  // SRAM stand-in: read data is the expected nibble with the injected fault bits flipped.
  assign act_now = exp_d ^ fault;
  always @(posedge clk) begin
    dout_a <= act_now;
    dly_b  <= act_now;
    dout_b <= dly_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic idle();
    we = 1'b1; eot = 1'b0; fault = 4'h0; start = 1'b0;
  endtask

  task automatic do_start();
    idle();
    start = 1'b1;
    step();
    start = 1'b0;
    sb_q.delete();
  endtask

  task automatic read(input logic [7:0] a, input logic [3:0] e, input logic [3:0] m);
    we = 1'b0; addr = a; exp_d = e; fault = m;
  endtask

  task automatic check_head();
    fail_entry_t e;
    check("sb_nonempty", sb_q.size() != 0, 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("log_valid", a_valid, 1);
      check("log_addr", a_laddr, e.addr);
      check("log_exp", a_lexp, e.exp);
      check("log_act", a_lact, e.act);
    end
  endtask

  task automatic pop_all(input int n);
    for (int i = 0; i < n; i++) begin
      check_head();
      log_pop = 1'b1;
      step();
      log_pop = 1'b0;
    end
    check("log_empty", a_valid, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_busy"}, a_busy, 0);   check({tag, "_a_done"}, a_done, 0);
    check({tag, "_a_pass"}, a_pass, 0);   check({tag, "_a_err"}, a_err, 0);
    check({tag, "_a_fb"}, a_fb, 0);       check({tag, "_a_valid"}, a_valid, 0);
    check({tag, "_a_laddr"}, a_laddr, 0); check({tag, "_a_lexp"}, a_lexp, 0);
    check({tag, "_a_lact"}, a_lact, 0);   check({tag, "_a_ovf"}, a_ovf, 0);
    check({tag, "_b_busy"}, b_busy, 0);   check({tag, "_b_done"}, b_done, 0);
    check({tag, "_b_pass"}, b_pass, 0);   check({tag, "_b_err"}, b_err, 0);
    check({tag, "_b_fb"}, b_fb, 0);       check({tag, "_b_valid"}, b_valid, 0);
    check({tag, "_b_ovf"}, b_ovf, 0);
  endtask

  // Read one failing row, then an idle cycle during which dut_a compares it.
  task automatic apply_row(input int i, input bit push_sb, input bit pop, input logic ovf_req);
    read(rows[i].addr, rows[i].exp, rows[i].mask);
    if (push_sb) sb_q.push_back('{rows[i].addr, rows[i].exp, rows[i].exp ^ rows[i].mask});
    step();
    idle();
    if (pop) begin
      check_head();
      log_pop = 1'b1;
    end
    step();
    log_pop = 1'b0;
    check($sformatf("row%0d_err", i), a_err, rows[i].err);
    check($sformatf("row%0d_fb", i), a_fb, rows[i].fb);
    check($sformatf("row%0d_ovf", i), a_ovf, ovf_req);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{8'h10, 4'h1, 4'h1, 1, 4'h1};
    rows[1] = '{8'h22, 4'h2, 4'h2, 2, 4'h3};
    rows[2] = '{8'h34, 4'hF, 4'h4, 3, 4'h7};
    rows[3] = '{8'hFF, 4'h0, 4'h8, 4, 4'hF};
    rows[4] = '{8'h00, 4'hA, 4'h1, 5, 4'hF};
    rows[5] = '{8'h01, 4'h5, 4'hF, 6, 4'hF};

    rst_n = 1'b0; log_pop = 1'b0; addr = '0; exp_d = '0;
    idle();
    step(); step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Fault-free march
    do_start();
    for (int i = 0; i < 256; i++) begin
      we = 1'b1; addr = 8'(i); exp_d = 4'(i);
      step();
    end
    for (int i = 0; i < 256; i++) begin
      read(8'(i), 4'(i), 4'h0);
      eot = (i == 255);
      step();
    end
    idle();
    check("ff_a_drain_busy", a_busy, 1);
    check("ff_a_drain_done", a_done, 0);
    step();
    check("ff_a_done", a_done, 1);
    check("ff_a_pass", a_pass, 1);
    check("ff_a_err", a_err, 0);
    check("ff_a_valid", a_valid, 0);
    check("ff_b_still_drain", b_done, 0);
    step();
    check("ff_b_done", b_done, 1);
    check("ff_b_pass", b_pass, 1);

    // Single fault at 0x5A
    do_start();
    read(8'h5A, 4'h0, 4'h3);
    sb_q.push_back('{8'h5A, 4'h0, 4'h3});
    step();
    idle();
    step();
    check("sf_a_err", a_err, 1);
    check("sf_a_fb", a_fb, 3);
    eot = 1'b1;
    step();
    eot = 1'b0;
    step(); step();
    check("sf_a_done", a_done, 1);
    check("sf_a_pass", a_pass, 0);
    check("sf_b_err", b_err, 1);
    check("sf_b_fb", b_fb, 3);
    check("sf_b_pass", b_pass, 0);
    eot = 1'b1;
    step();
    eot = 1'b0;
    check("eot_in_done_ignored", a_done, 1);
    pop_all(1);

    // Overflow with no pops, table-driven
    do_start();
    for (int i = 0; i < 6; i++) apply_row(i, i < 4, 1'b0, i >= 4);
    pop_all(4);
    check("sat_b_err", b_err, 3);
    check("sat_b_fb", b_fb, 4'hF);

    // Overflow with a pop on the 5th failure
    do_start();
    for (int i = 0; i < 4; i++) apply_row(i, 1'b1, 1'b0, 1'b0);
    apply_row(4, 1'b1, 1'b1, 1'b0);
    apply_row(5, 1'b0, 1'b0, 1'b1);
    pop_all(4);

    // Failing read in the end_of_test cycle, plus a read issued during DRAIN
    do_start();
    read(8'h77, 4'h6, 4'h9);
    eot = 1'b1;
    sb_q.push_back('{8'h77, 4'h6, 4'hF});
    step();
    read(8'h78, 4'h0, 4'hF);
    eot = 1'b0;
    step();
    idle();
    step();
    check("if_a_err", a_err, 1);
    check("if_a_done", a_done, 1);
    check("if_a_pass", a_pass, 0);
    check("if_b_err", b_err, 1);
    check("if_b_fb", b_fb, 4'h9);
    check("if_b_done", b_done, 1);
    check("if_b_pass", b_pass, 0);
    step(); step();
    check("if_b_err_late", b_err, 1);
    pop_all(1);

    // Restart mid-RUN, then reset mid-DRAIN
    do_start();
    for (int i = 1; i <= 3; i++) begin
      read(8'(i), 4'h0, 4'h1);
      step();
      idle();
      step();
    end
    check("rs_a_err_before", a_err, 3);
    do_start();
    check("rs_a_err", a_err, 0);
    check("rs_a_valid", a_valid, 0);
    check("rs_a_fb", a_fb, 0);
    check("rs_a_busy", a_busy, 1);
    check("rs_a_done", a_done, 0);
    check("rs_b_err", b_err, 0);
    eot = 1'b1;
    step();
    eot = 1'b0;
    check("rs_b_drain", b_busy, 1);
    rst_n = 1'b0;
    step();
    check_zero("rst_drain");
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
